// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 message schedule block.
// Word type, FSM state encoding and window geometry live here.
package sha256_pkg;

    localparam int WINDOW = 16;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_DONE
    } state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Small-sigma functions of the SHA-256 message schedule.
// s0 is applied to the W[t-15] tap, s1 to the W[t-2] tap.
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w15_i,
    input  logic [WORD_W-1:0] w2_i,
    output logic [WORD_W-1:0] s0_o,
    output logic [WORD_W-1:0] s1_o
);

    assign s0_o = rotr(w15_i, 7) ^ rotr(w15_i, 18) ^ (w15_i >> 3);
    assign s1_o = rotr(w2_i, 17) ^ rotr(w2_i, 19) ^ (w2_i >> 10);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W[0..15], expands W[16..ROUNDS-1].
// One word per cycle through a valid/ready output register.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_i_valid,
    output logic              data_i_ready,
    output logic [DATA_W-1:0] w_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [5:0]        round_o,
    output logic              done_o
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("sha256_msg_sched: DATA_W must be 32");
    end

    if (ROUNDS < 17 || ROUNDS > 64) begin : g_bad_rounds
        $error("sha256_msg_sched: ROUNDS must be 17..64");
    end

    localparam logic [6:0] LAST_LOAD = 7'd15;
    localparam logic [6:0] LAST_WORD = 7'(ROUNDS - 1);

    state_t     state_q;
    logic [6:0] cnt_q;
    word_t      win_q [WINDOW];
    word_t      w_q;
    logic       wv_q;
    logic [5:0] round_q;
    logic       done_q;

    word_t s0;
    word_t s1;
    word_t exp_w;
    word_t w_d;
    logic  slot_free;
    logic  accept;
    logic  issue;
    logic  step;

    sha256_sched_sigma u_sigma (
        .w15_i (win_q[14]),
        .w2_i  (win_q[1]),
        .s0_o  (s0),
        .s1_o  (s1)
    );

    always_comb begin
        slot_free = !wv_q || w_ready_i;
        accept    = (state_q == S_LOAD) && slot_free && data_i_valid;
        issue     = (state_q == S_EXPAND) && slot_free;
        step      = accept || issue;
        exp_w     = s1 + win_q[6] + s0 + win_q[15];
        w_d       = accept ? word_t'(data_i) : exp_w;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            wv_q    <= 1'b0;
            round_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < WINDOW; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // A new word may replace a consumed one in the same cycle.
            if (step) begin
                w_q     <= w_d;
                wv_q    <= 1'b1;
                round_q <= cnt_q[5:0];
                cnt_q   <= cnt_q + 7'd1;
                win_q[0] <= w_d;
                for (int i = 1; i < WINDOW; i++) begin
                    win_q[i] <= win_q[i-1];
                end
            end else if (w_ready_i) begin
                wv_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept && cnt_q == LAST_LOAD) begin
                        state_q <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (issue && cnt_q == LAST_WORD) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (wv_q && w_ready_i) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign data_i_ready = (state_q == S_LOAD) && slot_free;
    assign w_o          = DATA_W'(w_q);
    assign w_valid_o    = wv_q;
    assign round_o      = round_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched (ROUNDS=64 and ROUNDS=17).
// Drivers queue expected words; monitors pop on each output handshake.
module tb_sha256_msg_sched;

    typedef logic [31:0] blk_t [16];
    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  r;
        logic        last;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        start17;
    logic [31:0] data_i;
    logic        data_i_valid;
    logic        w_ready_i;

    logic        data_i_ready, w_valid_o, done_o;
    logic [31:0] w_o;
    logic [5:0]  round_o;
    logic        rdy17, wv17, d17;
    logic [31:0] w17;
    logic [5:0]  r17;

    exp_t        q64[$];
    exp_t        q17[$];
    int          checks = 0;
    int          errors = 0;
    int          done64 = 0;
    int          done17 = 0;
    int          n64 = 0;
    int          n17 = 0;
    logic [31:0] got64 [64];
    logic [31:0] got17 [64];
    logic [31:0] sched [64];
    bit          rnd_ready = 1'b0;
    blk_t        abc;
    blk_t        zblk;

    always #5 CLK = ~CLK;

    sha256_msg_sched dut (
        .CLK(CLK), .RST(RST), .start(start),
        .data_i(data_i), .data_i_valid(data_i_valid),
        .data_i_ready(data_i_ready),
        .w_o(w_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .round_o(round_o), .done_o(done_o)
    );

    sha256_msg_sched #(.ROUNDS(17)) dut17 (
        .CLK(CLK), .RST(RST), .start(start17),
        .data_i(data_i), .data_i_valid(data_i_valid),
        .data_i_ready(rdy17),
        .w_o(w17), .w_valid_o(wv17), .w_ready_i(w_ready_i),
        .round_o(r17), .done_o(d17)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic model(input blk_t b);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) sched[t] = b[t];
            else sched[t] = (rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10))
                          + sched[t-7]
                          + (rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3))
                          + sched[t-16];
        end
    endtask

    initial begin : ready_drv
        w_ready_i = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            w_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : mon64
        bit exp_done;
        bit stall;
        logic [31:0] pw;
        logic [5:0] pr;
        exp_t e;
        exp_done = 0;
        stall = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_done = 0;
                stall = 0;
                continue;
            end
            if (done_o || exp_done) chk("done64", 32'(done_o), 32'(exp_done));
            if (done_o) done64++;
            if (stall) begin
                chk("hold_w64", w_o, pw);
                chk("hold_r64", 32'(round_o), 32'(pr));
                chk("hold_v64", 32'(w_valid_o), 32'd1);
            end
            exp_done = 0;
            stall = w_valid_o && !w_ready_i;
            pw = w_o;
            pr = round_o;
            if (w_valid_o && w_ready_i) begin
                if (q64.size() == 0) begin
                    chk("extra_word64", w_o, 32'hFFFF_FFFF);
                end else begin
                    e = q64.pop_front();
                    chk("w64", w_o, e.w);
                    chk("round64", 32'(round_o), 32'(e.r));
                    got64[e.r] = w_o;
                    n64++;
                    exp_done = e.last;
                end
            end
        end
    end

    initial begin : mon17
        bit exp_done;
        exp_t e;
        exp_done = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_done = 0;
                continue;
            end
            if (d17 || exp_done) chk("done17", 32'(d17), 32'(exp_done));
            if (d17) done17++;
            exp_done = 0;
            if (wv17 && w_ready_i) begin
                if (q17.size() == 0) begin
                    chk("extra_word17", w17, 32'hFFFF_FFFF);
                end else begin
                    e = q17.pop_front();
                    chk("w17", w17, e.w);
                    chk("round17", 32'(r17), 32'(e.r));
                    got17[e.r] = w17;
                    n17++;
                    exp_done = e.last;
                end
            end
        end
    end

    task automatic load_block(input bit sel, input blk_t b,
                              input bit rnd, input bit inj);
        int nr;
        int i;
        int budget;
        exp_t x;
        nr = sel ? 17 : 64;
        i = 0;
        budget = 2000;
        model(b);
        for (int t = 0; t < 64; t++) begin
            got64[t] = 32'hDEAD_BEEF;
            got17[t] = 32'hDEAD_BEEF;
        end
        n64 = 0;
        n17 = 0;
        for (int t = 0; t < nr; t++) begin
            x = '{w: sched[t], r: 6'(t), last: (t == nr - 1)};
            if (sel) q17.push_back(x);
            else q64.push_back(x);
        end
        if (sel) start17 = 1'b1;
        else start = 1'b1;
        data_i = b[0];
        data_i_valid = 1'b1;
        while (i < 16 && budget > 0) begin
            @(negedge CLK);
            if (data_i_valid && (sel ? rdy17 : data_i_ready)) i++;
            @(posedge CLK);
            #1;
            start = 1'b0;
            start17 = 1'b0;
            budget--;
            if (inj && i == 5) start = 1'b1;
            data_i = b[i & 15];
            data_i_valid = (i < 16) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        data_i_valid = 1'b0;
        start = 1'b0;
        chk("load_words", 32'(i), 32'd16);
        if (inj) begin
            repeat (3) begin
                start = 1'b1;
                @(posedge CLK);
                #1;
            end
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input bit sel);
        int prev;
        int budget;
        prev = sel ? done17 : done64;
        budget = 1000;
        while ((sel ? done17 : done64) == prev && budget > 0) begin
            @(posedge CLK);
            #1;
            budget--;
        end
        chk("done_seen", 32'(budget > 0), 32'd1);
        chk("nwords", sel ? 32'(n17) : 32'(n64), sel ? 32'd17 : 32'd64);
        chk("queue_empty", sel ? 32'(q17.size()) : 32'(q64.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_w"}, w_o, 32'd0);
        chk({tag, "_v"}, 32'(w_valid_o), 32'd0);
        chk({tag, "_r"}, 32'(round_o), 32'd0);
        chk({tag, "_d"}, 32'(done_o), 32'd0);
        chk({tag, "_rdy"}, 32'(data_i_ready), 32'd0);
    endtask

    initial begin : main
        logic [31:0] acc;
        int budget;
        abc = '{default: 32'd0};
        abc[0] = 32'h6162_6380;
        abc[15] = 32'h0000_0018;
        zblk = '{default: 32'd0};
        RST = 1'b1;
        start = 1'b0;
        start17 = 1'b0;
        data_i = '0;
        data_i_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_idle("reset");

        load_block(0, abc, 0, 0);
        wait_done(0);
        chk("abc_W16", got64[16], 32'h6162_6380);
        chk("abc_W17", got64[17], 32'h000F_0000);

        rnd_ready = 1'b1;
        load_block(0, abc, 1, 0);
        wait_done(0);
        load_block(0, abc, 1, 1);
        wait_done(0);
        rnd_ready = 1'b0;
        chk("inj_W17", got64[17], 32'h000F_0000);

        load_block(0, abc, 0, 0);
        budget = 500;
        while (!(w_valid_o && round_o == 6'd20) && budget > 0) begin
            @(posedge CLK);
            #1;
            budget--;
        end
        chk("reach_r20", 32'(budget > 0), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_idle("midreset");
        q64.delete();
        data_i_valid = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("no_resume_rdy", 32'(data_i_ready), 32'd0);
            chk("no_resume_v", 32'(w_valid_o), 32'd0);
        end
        data_i_valid = 1'b0;
        load_block(0, abc, 0, 0);
        wait_done(0);
        chk("post_rst_W16", got64[16], 32'h6162_6380);
        chk("post_rst_W17", got64[17], 32'h000F_0000);

        load_block(0, abc, 0, 0);
        wait_done(0);
        load_block(0, zblk, 0, 0);
        wait_done(0);
        acc = '0;
        for (int t = 16; t < 64; t++) acc |= got64[t];
        chk("zero_W16_63", acc, 32'd0);

        load_block(1, abc, 0, 0);
        wait_done(1);
        chk("r17_W16", got17[16], 32'h6162_6380);

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 Parameter ROUNDS, default 64, number of schedule words W[0..ROUNDS-1] produced per block (legal range 17..64).
REQ-002 Parameter DATA_W, default 32, word width; only 32 is legal, checked by an elaboration-time assertion.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a new block; sampled only in IDLE.
REQ-006 data_i  input  DATA_W  message word, big-endian word order W[0] first.
REQ-007 data_i_valid  input  1  data_i holds a valid word.
REQ-008 data_i_ready  output  1  block accepts data_i this cycle.
REQ-009 w_o  output  DATA_W  current schedule word W[t].
REQ-010 w_valid_o  output  1  w_o holds a valid word.
REQ-011 w_ready_i  input  1  consumer takes w_o this cycle when w_valid_o=1.
REQ-012 round_o  output  6  index t of the word on w_o.
REQ-013 done_o  output  1  one-cycle pulse after W[ROUNDS-1] is consumed.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, EXPAND and DONE.
REQ-015 IDLE: start=1 -> LOAD, word counter cleared to 0; start outside IDLE SHALL be ignored.
REQ-016 The output slot is free when w_valid_o=0 or w_ready_i=1; the output register SHALL advance only when the slot is free.
REQ-017 LOAD: data_i_ready SHALL equal the slot-free term; data_i_ready SHALL be 0 in all other states.
REQ-018 On an accept (data_i_valid and data_i_ready), the next cycle SHALL show w_o=data_i, w_valid_o=1, round_o=counter, with 1-cycle latency.
REQ-019 Every accepted word SHALL also be shifted into a 16-entry window, oldest entry discarded.
REQ-020 Accepting word 15 SHALL move the state LOAD -> EXPAND.
REQ-021 EXPAND, slot free: the block SHALL issue W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32, one word per cycle, and shift it into the window.
REQ-022 sigma0(x) SHALL be ROTR7^ROTR18^SHR3; sigma1(x) SHALL be ROTR17^ROTR19^SHR10.
REQ-023 Issuing word ROUNDS-1 SHALL move the state to DONE.
REQ-024 DONE: once w_valid_o=1 and w_ready_i=1, the block SHALL assert done_o for exactly one cycle, then w_valid_o=0 and state IDLE.
REQ-025 When the slot is not free, w_o, round_o and the window SHALL hold unchanged, with no word lost or duplicated under backpressure.
REQ-026 If w_ready_i=1 and a new word is issued in the same cycle, the new word SHALL replace the consumed one with no bubble.
REQ-027 When w_valid_o=1 is consumed with no new word issued, w_valid_o SHALL go to 0 next cycle.
REQ-028 A new start SHALL be accepted in the cycle after done_o, with no stale window content affecting W[16..].

Reset
REQ-029 RST=1 at a rising edge SHALL force IDLE, counter 0, window all zeros, w_o=0, w_valid_o=0, round_o=0, done_o=0, data_i_ready=0.
REQ-030 RST SHALL take priority over start, accepts and issues in the same cycle, including mid-LOAD and mid-EXPAND, with no partial block resuming afterwards.

Structure
REQ-031 Package sha256_pkg SHALL hold the state enum, WINDOW=16 and the word type (DATA_W-bit logic).
REQ-032 sigma0/sigma1 SHALL live in one combinational sub-module sha256_sched_sigma, instantiated once for the W[t-15] and W[t-2] taps.
REQ-033 The window SHALL be a plain shift register with fixed taps at positions 1, 6, 14 and 15 (newest = 0); no RAM.

Verification
REQ-034 Bench SHALL cover reset then the padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) with w_ready_i=1 -> W16=0x61626380, W17=0x000F0000; 64 words total; done_o one cycle after W63 is taken.
REQ-035 Bench SHALL cover the same block with w_ready_i random 50% and data_i_valid random -> identical word sequence, round_o contiguous 0..63, no duplicates.
REQ-036 Bench SHALL cover RST pulsed at round_o=20 -> next cycle all outputs 0 and state IDLE; a new "abc" block then yields the same W16/W17.
REQ-037 Bench SHALL cover start pulsed during LOAD and EXPAND -> no effect on the sequence.
REQ-038 Bench SHALL cover ROUNDS=17 -> exactly 17 words, W16=0x61626380, then done_o.
REQ-039 Bench SHALL cover back-to-back blocks ("abc" then all-0x00000000) -> second block yields W16..W63 all 0.
